// File: rtl/dmem_arb.sv
// dmem_arb: two-requester arbiter in front of a single data-memory port.
// The CPU wins by default; a starvation guard and locked DMA bursts bound the loader's latency.

`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

module dmem_arb #(
    parameter int ADDR_W    = `SIZE_ADDR,
    parameter int DATA_W    = `SIZE_DATA,
    parameter int MAX_WAIT  = 4,
    parameter int BURST_MAX = 8
) (
    input  logic              iw_clk,
    input  logic              iw_rst,

    input  logic              iw_cpu_req,
    input  logic              iw_cpu_we,
    input  logic [ADDR_W-1:0] iw_cpu_addr,
    input  logic [DATA_W-1:0] iw_cpu_wdata,
    output logic              ow_cpu_gnt,
    output logic              ow_cpu_rvalid,
    output logic [DATA_W-1:0] ow_cpu_rdata,
    output logic              ow_stall,

    input  logic              iw_dma_req,
    input  logic              iw_dma_lock,
    input  logic              iw_dma_we,
    input  logic [ADDR_W-1:0] iw_dma_addr,
    input  logic [DATA_W-1:0] iw_dma_wdata,
    output logic              ow_dma_gnt,
    output logic              ow_dma_rvalid,
    output logic [DATA_W-1:0] ow_dma_rdata,

    output logic              ow_mem_we,
    output logic [ADDR_W-1:0] ow_mem_addr,
    output logic [DATA_W-1:0] ow_mem_wdata,
    input  logic [DATA_W-1:0] iw_mem_rdata
);

    localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam int BURST_W = $clog2(BURST_MAX + 1);

    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MAX_WAIT - 1);
    localparam logic [WAIT_W-1:0]  WAIT_ZERO  = '0;
    localparam logic [WAIT_W-1:0]  WAIT_ONE   = WAIT_W'(1);
    localparam logic [BURST_W-1:0] BURST_ONE  = BURST_W'(1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_MAX);

    typedef enum logic [1:0] {
        S_CPU   = 2'd0,
        S_FORCE = 2'd1,
        S_LOCK  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [BURST_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [BURST_W-1:0]  burst_next;
    logic                cool_q, cool_d;
    logic                cpu_rvalid_q, cpu_rvalid_d;
    logic                dma_rvalid_q, dma_rvalid_d;
    logic                cpu_gnt, dma_gnt;

    // Grants depend only on the current state and requests; both are forced low in reset.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        case (state_q)
            S_CPU: begin
                cpu_gnt = iw_cpu_req;
                dma_gnt = iw_dma_req & ~iw_cpu_req;
            end
            S_FORCE: begin
                dma_gnt = iw_dma_req;
                cpu_gnt = iw_cpu_req & ~iw_dma_req;
            end
            S_LOCK: begin
                dma_gnt = iw_dma_req;
            end
            default: begin
                cpu_gnt = 1'b0;
                dma_gnt = 1'b0;
            end
        endcase
        if (iw_rst) begin
            cpu_gnt = 1'b0;
            dma_gnt = 1'b0;
        end
    end

    always_comb begin
        ow_mem_we    = 1'b0;
        ow_mem_addr  = iw_cpu_addr;
        ow_mem_wdata = iw_cpu_wdata;
        if (dma_gnt) begin
            ow_mem_we    = iw_dma_we;
            ow_mem_addr  = iw_dma_addr;
            ow_mem_wdata = iw_dma_wdata;
        end else if (cpu_gnt) begin
            ow_mem_we    = iw_cpu_we;
        end
        if (iw_rst) begin
            ow_mem_we    = 1'b0;
            ow_mem_addr  = '0;
            ow_mem_wdata = '0;
        end
    end

    // burst_cnt counts grants of the current burst including this one, so the
    // burst ends on the grant that brings it to BURST_MAX.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        burst_cnt_d  = burst_cnt_q;
        cool_d       = 1'b0;
        burst_next   = (burst_cnt_q < BURST_LAST) ? (burst_cnt_q + BURST_ONE) : burst_cnt_q;
        cpu_rvalid_d = cpu_gnt & ~iw_cpu_we;
        dma_rvalid_d = dma_gnt & ~iw_dma_we;

        case (state_q)
            S_CPU: begin
                if (dma_gnt || !iw_dma_req) begin
                    wait_cnt_d = WAIT_ZERO;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_FORCE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_ONE;
                end
                if (dma_gnt && iw_dma_lock && !cool_q) begin
                    burst_cnt_d = BURST_ONE;
                    if (BURST_ONE == BURST_LAST) begin
                        cool_d = 1'b1;
                    end else begin
                        state_d = S_LOCK;
                    end
                end
            end
            S_FORCE: begin
                wait_cnt_d = WAIT_ZERO;
                state_d    = S_CPU;
                if (dma_gnt && iw_dma_lock && !cool_q) begin
                    burst_cnt_d = BURST_ONE;
                    if (BURST_ONE == BURST_LAST) begin
                        cool_d = 1'b1;
                    end else begin
                        state_d = S_LOCK;
                    end
                end
            end
            S_LOCK: begin
                wait_cnt_d = WAIT_ZERO;
                if (dma_gnt) begin
                    burst_cnt_d = burst_next;
                end
                if (!iw_dma_lock || !iw_dma_req || (dma_gnt && burst_next == BURST_LAST)) begin
                    state_d = S_CPU;
                    cool_d  = 1'b1;
                end
            end
            default: begin
                state_d    = S_CPU;
                wait_cnt_d = WAIT_ZERO;
            end
        endcase
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            state_q      <= S_CPU;
            wait_cnt_q   <= '0;
            burst_cnt_q  <= '0;
            cool_q       <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            cool_q       <= cool_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dma_rvalid_q <= dma_rvalid_d;
        end
    end

    assign ow_cpu_gnt    = cpu_gnt;
    assign ow_dma_gnt    = dma_gnt;
    assign ow_stall      = iw_cpu_req & ~cpu_gnt;
    assign ow_cpu_rvalid = cpu_rvalid_q;
    assign ow_dma_rvalid = dma_rvalid_q;
    assign ow_cpu_rdata  = iw_mem_rdata;
    assign ow_dma_rdata  = iw_mem_rdata;

    a_single_grant: assert property (@(posedge iw_clk) disable iff (iw_rst) !(cpu_gnt && dma_gnt));

endmodule

// File: tb/tb_dmem_arb.sv
// tb_dmem_arb: scenario tasks with a read-data scoreboard for dmem_arb.
// A registered memory model sits on the mem port; expected reads come from a shadow copy.

module tb_dmem_arb;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 32;
    localparam int MAX_WAIT  = 4;
    localparam int BURST_MAX = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt, cpu_rvalid, stall;
    logic [DATA_W-1:0] cpu_rdata;
    logic              dma_req, dma_lock, dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt, dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int checks;
    int errors;
    logic [DATA_W-1:0] cpu_exp_q[$];
    logic [DATA_W-1:0] dma_exp_q[$];
    logic [DATA_W-1:0] shadow [0:255];
    logic [DATA_W-1:0] mem [0:255];
    logic              mem_loaded = 1'b0;
    logic [DATA_W-1:0] mon_exp;

    dmem_arb #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)
    ) dut (
        .iw_clk(clk), .iw_rst(rst),
        .iw_cpu_req(cpu_req), .iw_cpu_we(cpu_we), .iw_cpu_addr(cpu_addr), .iw_cpu_wdata(cpu_wdata),
        .ow_cpu_gnt(cpu_gnt), .ow_cpu_rvalid(cpu_rvalid), .ow_cpu_rdata(cpu_rdata), .ow_stall(stall),
        .iw_dma_req(dma_req), .iw_dma_lock(dma_lock), .iw_dma_we(dma_we), .iw_dma_addr(dma_addr),
        .iw_dma_wdata(dma_wdata), .ow_dma_gnt(dma_gnt), .ow_dma_rvalid(dma_rvalid), .ow_dma_rdata(dma_rdata),
        .ow_mem_we(mem_we), .ow_mem_addr(mem_addr), .ow_mem_wdata(mem_wdata), .iw_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] init_word(input int i);
        return (i == 16) ? 32'h0000_00AB : (32'hC000_0000 | 32'(i));
    endfunction

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr[7:0]];
    end

    // Every rvalid must match the oldest outstanding expected read of that requester.
    always @(negedge clk) begin
        if (!rst) begin
            if (cpu_rvalid) begin
                checks++;
                if (cpu_exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL cpu_rvalid_unexpected rdata=%h, no read was outstanding", cpu_rdata);
                end else begin
                    mon_exp = cpu_exp_q.pop_front();
                    if (cpu_rdata !== mon_exp) begin
                        errors++;
                        $display("[TB] FAIL cpu_rdata got=%h expected=%h", cpu_rdata, mon_exp);
                    end
                end
            end
            if (dma_rvalid) begin
                checks++;
                if (dma_exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL dma_rvalid_unexpected rdata=%h, no read was outstanding", dma_rdata);
                end else begin
                    mon_exp = dma_exp_q.pop_front();
                    if (dma_rdata !== mon_exp) begin
                        errors++;
                        $display("[TB] FAIL dma_rdata got=%h expected=%h", dma_rdata, mon_exp);
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_lock = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    endtask

    task automatic test_reset();
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0033; cpu_wdata = 32'h1234_5678;
        dma_req = 1; dma_we = 1; dma_addr = 16'h0044; dma_wdata = 32'h8765_4321;
        @(negedge clk);
        checks++;
        if (cpu_gnt !== 1'b0 || dma_gnt !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_gnt cpu=%b dma=%b expected 0 0", cpu_gnt, dma_gnt);
        end
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mem we=%b addr=%h wdata=%h expected all zero", mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_rvalid cpu=%b dma=%b expected 0 0", cpu_rvalid, dma_rvalid);
        end
        next_cycle();
        rst = 0;
        idle();
    endtask

    task automatic test_cpu_read();
        next_cycle();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        @(negedge clk);
        checks++;
        if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cpu_read_gnt cpu=%b dma=%b stall=%b expected 1 0 0", cpu_gnt, dma_gnt, stall);
        end
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 16'h0010) begin
            errors++;
            $display("[TB] FAIL cpu_read_mem we=%b addr=%h expected 0 0010", mem_we, mem_addr);
        end
        cpu_exp_q.push_back(shadow[8'h10]);
        next_cycle();
        idle();
        @(negedge clk);
        checks++;
        if (cpu_rvalid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL cpu_read_rvalid got=%b expected 1", cpu_rvalid);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (cpu_rvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cpu_read_rvalid_drop got=%b expected 0", cpu_rvalid);
        end
    endtask

    task automatic test_starvation();
        logic exp_dma;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            exp_dma = (c == MAX_WAIT);
            cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0030 + 16'(c);
            dma_req = 1; dma_lock = 0; dma_we = 0; dma_addr = 16'h0040;
            @(negedge clk);
            checks++;
            if (dma_gnt !== exp_dma || cpu_gnt !== !exp_dma || stall !== exp_dma) begin
                errors++;
                $display("[TB] FAIL starve_gnt c=%0d cpu=%b dma=%b stall=%b expected %b %b %b",
                         c, cpu_gnt, dma_gnt, stall, !exp_dma, exp_dma, exp_dma);
            end
            if (exp_dma) dma_exp_q.push_back(shadow[8'h40]);
            else         cpu_exp_q.push_back(shadow[cpu_addr[7:0]]);
        end
        next_cycle();
        idle();
        @(negedge clk);
    endtask

    task automatic test_lock_burst();
        int   grants = 0;
        int   seen   = 0;
        logic exp_dma;
        for (int c = 0; c < 13; c++) begin
            next_cycle();
            exp_dma = (c >= MAX_WAIT) && (c < MAX_WAIT + BURST_MAX);
            cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0050;
            dma_req = 1; dma_lock = 1; dma_we = 1;
            dma_addr  = 16'h0020 + 16'(grants);
            dma_wdata = 32'hD000_0000 + 32'(grants);
            @(negedge clk);
            checks++;
            if (dma_gnt !== exp_dma || cpu_gnt !== !exp_dma || stall !== exp_dma) begin
                errors++;
                $display("[TB] FAIL burst_gnt c=%0d cpu=%b dma=%b stall=%b expected %b %b %b",
                         c, cpu_gnt, dma_gnt, stall, !exp_dma, exp_dma, exp_dma);
            end
            if (dma_gnt === 1'b1) seen++;
            if (exp_dma) begin
                checks++;
                if (mem_we !== 1'b1 || mem_addr !== dma_addr || mem_wdata !== dma_wdata) begin
                    errors++;
                    $display("[TB] FAIL burst_mem c=%0d we=%b addr=%h wdata=%h expected 1 %h %h",
                             c, mem_we, mem_addr, mem_wdata, dma_addr, dma_wdata);
                end
                shadow[dma_addr[7:0]] = dma_wdata;
                grants++;
            end else begin
                cpu_exp_q.push_back(shadow[8'h50]);
            end
        end
        checks++;
        if (seen != BURST_MAX) begin
            errors++;
            $display("[TB] FAIL burst_len got=%0d expected=%0d", seen, BURST_MAX);
        end
        next_cycle();
        idle();
        @(negedge clk);
    endtask

    task automatic test_lock_drop();
        int   grants = 0;
        int   second = 0;
        logic exp_dma;
        for (int c = 0; c < 21; c++) begin
            next_cycle();
            exp_dma = (c >= 4 && c <= 7) || (c >= 12 && c <= 19);
            cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0051;
            dma_req = 1; dma_lock = (c != 7); dma_we = 1;
            dma_addr  = 16'h0060 + 16'(grants);
            dma_wdata = 32'hE000_0000 + 32'(grants);
            @(negedge clk);
            checks++;
            if (dma_gnt !== exp_dma || cpu_gnt !== !exp_dma) begin
                errors++;
                $display("[TB] FAIL lockdrop_gnt c=%0d cpu=%b dma=%b expected %b %b",
                         c, cpu_gnt, dma_gnt, !exp_dma, exp_dma);
            end
            if (c >= 12 && dma_gnt === 1'b1) second++;
            if (exp_dma) begin
                shadow[dma_addr[7:0]] = dma_wdata;
                grants++;
            end else begin
                cpu_exp_q.push_back(shadow[8'h51]);
            end
        end
        checks++;
        if (second != BURST_MAX) begin
            errors++;
            $display("[TB] FAIL relock_len got=%0d expected=%0d", second, BURST_MAX);
        end
        next_cycle();
        idle();
        @(negedge clk);
    endtask

    task automatic test_simultaneous_write();
        next_cycle();
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0008; cpu_wdata = 32'h0000_0055;
        dma_req = 1; dma_lock = 0; dma_we = 0; dma_addr = 16'h0008;
        @(negedge clk);
        checks++;
        if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0) begin
            errors++;
            $display("[TB] FAIL simul_gnt cpu=%b dma=%b expected 1 0", cpu_gnt, dma_gnt);
        end
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 16'h0008 || mem_wdata !== 32'h0000_0055) begin
            errors++;
            $display("[TB] FAIL simul_mem we=%b addr=%h wdata=%h expected 1 0008 00000055", mem_we, mem_addr, mem_wdata);
        end
        shadow[8'h08] = 32'h0000_0055;
        next_cycle();
        cpu_req = 0; cpu_we = 0;
        @(negedge clk);
        checks++;
        if (dma_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL simul_no_rvalid cpu=%b dma=%b expected 0 0", cpu_rvalid, dma_rvalid);
        end
        checks++;
        if (dma_gnt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL simul_dma_read_gnt got=%b expected 1", dma_gnt);
        end
        dma_exp_q.push_back(shadow[8'h08]);
        next_cycle();
        idle();
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        next_cycle();
        dma_req = 1; dma_lock = 1; dma_we = 0; dma_addr = 16'h0070;
        @(negedge clk);
        checks++;
        if (dma_gnt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_first_gnt got=%b expected 1", dma_gnt);
        end
        dma_exp_q.push_back(shadow[8'h70]);
        next_cycle();
        dma_addr = 16'h0071;
        @(negedge clk);
        checks++;
        if (dma_gnt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_lock_gnt got=%b expected 1", dma_gnt);
        end
        next_cycle();
        rst = 1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        @(negedge clk);
        checks++;
        if (dma_rvalid !== 1'b0 || cpu_gnt !== 1'b0 || dma_gnt !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_during rvalid=%b cpu_gnt=%b dma_gnt=%b expected 0 0 0",
                     dma_rvalid, cpu_gnt, dma_gnt);
        end
        next_cycle();
        rst = 0;
        @(negedge clk);
        checks++;
        if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_after cpu=%b dma=%b stall=%b expected 1 0 0", cpu_gnt, dma_gnt, stall);
        end
        cpu_exp_q.push_back(shadow[8'h10]);
        next_cycle();
        idle();
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1;
        idle();
        for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
        test_reset();
        test_cpu_read();
        test_starvation();
        test_lock_burst();
        test_lock_drop();
        test_simultaneous_write();
        test_reset_mid_burst();
        repeat (3) next_cycle();
        checks++;
        if (cpu_exp_q.size() != 0 || dma_exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL outstanding_reads cpu=%0d dma=%0d expected 0 0", cpu_exp_q.size(), dma_exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
